// File: rtl/vx_gpr_pkg.sv
// vx_gpr_pkg: shared types and index helpers for the GPR file.
package vx_gpr_pkg;
   typedef enum logic {GPR_INIT, GPR_RUN} gpr_state_e;
   function automatic int gpr_addrw(input int num_warps, input int num_regs);
      return $clog2(num_warps) + $clog2(num_regs);
   endfunction
   // rsp_data is port-major, then lane
   function automatic int gpr_rsp_idx(input int p, input int t, input int num_threads, input int dataw);
      return (p * num_threads + t) * dataw;
   endfunction
endpackage

// File: rtl/vx_gpr_file_if.sv
// vx_gpr_file_if: writeback, read request and read response channels of the GPR file.
interface vx_gpr_file_if #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_REGS    = 32,
   parameter int NUM_THREADS = 4,
   parameter int DATAW       = 32,
   parameter int NUM_RPORTS  = 3
);
   localparam int WIDW = $clog2(NUM_WARPS);
   localparam int REGW = $clog2(NUM_REGS);
   logic                                wb_valid;
   logic                                wb_ready;
   logic [WIDW-1:0]                     wb_wid;
   logic [REGW-1:0]                     wb_rd;
   logic [NUM_THREADS-1:0]              wb_tmask;
   logic [NUM_THREADS*DATAW-1:0]        wb_data;
   logic                                req_valid;
   logic                                req_ready;
   logic [WIDW-1:0]                     req_wid;
   logic [NUM_RPORTS*REGW-1:0]          req_rs;
   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [WIDW-1:0]                     rsp_wid;
   logic [NUM_RPORTS*NUM_THREADS*DATAW-1:0] rsp_data;
   logic                                init_done;
   modport master (
      output wb_valid, wb_wid, wb_rd, wb_tmask, wb_data, req_valid, req_wid, req_rs, rsp_ready,
      input  wb_ready, req_ready, rsp_valid, rsp_wid, rsp_data, init_done
   );
   modport slave (
      input  wb_valid, wb_wid, wb_rd, wb_tmask, wb_data, req_valid, req_wid, req_rs, rsp_ready,
      output wb_ready, req_ready, rsp_valid, rsp_wid, rsp_data, init_done
   );
endinterface

// File: rtl/vx_gpr_bank.sv
// vx_gpr_bank: one read port's copy of the register storage, per-lane write enable.
module vx_gpr_bank #(
   parameter int SIZE        = 128,
   parameter int ADDRW       = 7,
   parameter int NUM_THREADS = 4,
   parameter int DATAW       = 32
) (
   input  logic                         clk,
   input  logic [NUM_THREADS-1:0]       we,
   input  logic [ADDRW-1:0]             waddr,
   input  logic [NUM_THREADS*DATAW-1:0] wdata,
   input  logic [ADDRW-1:0]             raddr,
   output logic [NUM_THREADS*DATAW-1:0] rdata
);
   logic [DATAW-1:0] mem [NUM_THREADS][SIZE];
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_THREADS; i++)
         if (we[i]) mem[i][waddr] <= wdata[i*DATAW +: DATAW];
   end
   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
      assign rdata[t*DATAW +: DATAW] = mem[t][raddr];
   end
endmodule

// File: rtl/vx_gpr_file.sv
// vx_gpr_file: multi-port per-lane GPR file with post-reset clear,
// optional writeback bypass and a registered, back-pressured read response.
module vx_gpr_file import vx_gpr_pkg::*; #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_REGS    = 32,
   parameter int NUM_THREADS = 4,
   parameter int DATAW       = 32,
   parameter int NUM_RPORTS  = 3,
   parameter int BYPASS      = 1
) (
   input logic          clk,
   input logic          reset,
   vx_gpr_file_if.slave gpr
);
   localparam int WIDW  = $clog2(NUM_WARPS);
   localparam int REGW  = $clog2(NUM_REGS);
   localparam int ADDRW = gpr_addrw(NUM_WARPS, NUM_REGS);
   localparam int LW    = NUM_THREADS * DATAW;
   localparam int RW    = NUM_RPORTS * LW;

   gpr_state_e             state_q, state_d;
   logic [ADDRW-1:0]       cnt_q, cnt_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [WIDW-1:0]        rsp_wid_q, rsp_wid_d;
   logic [RW-1:0]          rsp_data_q, rsp_data_d, rd_data;
   logic [NUM_THREADS-1:0] bank_we;
   logic [ADDRW-1:0]       bank_waddr;
   logic [LW-1:0]          bank_wdata;
   logic [LW-1:0]          bank_rdata [NUM_RPORTS];
   logic                   run, wr_run, accept;

   assign run    = state_q == GPR_RUN;
   assign wr_run = run && gpr.wb_valid && gpr.wb_rd != '0;
   assign accept = gpr.req_valid && gpr.req_ready;

   assign gpr.wb_ready  = run;
   assign gpr.init_done = run;
   assign gpr.req_ready = run && (!rsp_valid_q || gpr.rsp_ready);
   assign gpr.rsp_valid = rsp_valid_q;
   assign gpr.rsp_wid   = rsp_wid_q;
   assign gpr.rsp_data  = rsp_data_q;

   // The clear sequence owns the shared write port until RUN
   assign bank_we    = !run ? '1 : (wr_run ? gpr.wb_tmask : '0);
   assign bank_waddr = !run ? cnt_q : {gpr.wb_wid, gpr.wb_rd};
   assign bank_wdata = !run ? '0 : gpr.wb_data;

   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_bank
      vx_gpr_bank #(
         .SIZE(2**ADDRW), .ADDRW(ADDRW), .NUM_THREADS(NUM_THREADS), .DATAW(DATAW)
      ) bank (
         .clk   (clk),
         .we    (bank_we),
         .waddr (bank_waddr),
         .wdata (bank_wdata),
         .raddr ({gpr.req_wid, gpr.req_rs[p*REGW +: REGW]}),
         .rdata (bank_rdata[p])
      );
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RPORTS; p++)
         for (int t = 0; t < NUM_THREADS; t++)
            rd_data[gpr_rsp_idx(p, t, NUM_THREADS, DATAW) +: DATAW] =
               gpr.req_rs[p*REGW +: REGW] == '0 ? '0 :
               (BYPASS != 0 && wr_run && gpr.wb_tmask[t] && gpr.wb_wid == gpr.req_wid &&
                gpr.wb_rd == gpr.req_rs[p*REGW +: REGW]) ? gpr.wb_data[t*DATAW +: DATAW] :
               bank_rdata[p][t*DATAW +: DATAW];
      state_d     = (!run && &cnt_q) ? GPR_RUN : state_q;
      cnt_d       = run ? cnt_q : cnt_q + ADDRW'(1);
      rsp_valid_d = accept || (rsp_valid_q && !gpr.rsp_ready);
      rsp_wid_d   = accept ? gpr.req_wid : rsp_wid_q;
      rsp_data_d  = accept ? rd_data : rsp_data_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= GPR_INIT;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_wid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wid_q   <= rsp_wid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end
endmodule

// File: tb/tb_vx_gpr_file.sv
// tb_vx_gpr_file: randomized and directed checks of vx_gpr_file (BYPASS=1 and BYPASS=0
// instances on shared stimulus) against an array-based model of the register file.
module tb_vx_gpr_file;
   localparam int NW = 4, NR = 32, NT = 4, DW = 32, NP = 3;
   localparam int RAM = NW * NR;
   localparam int RW  = NP * NT * DW;

   logic clk = 0, reset = 1;
   always #5 clk = ~clk;

   vx_gpr_file_if #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .DATAW(DW), .NUM_RPORTS(NP)) g ();
   vx_gpr_file_if #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .DATAW(DW), .NUM_RPORTS(NP)) g0 ();

   assign g0.wb_valid  = g.wb_valid;
   assign g0.wb_wid    = g.wb_wid;
   assign g0.wb_rd     = g.wb_rd;
   assign g0.wb_tmask  = g.wb_tmask;
   assign g0.wb_data   = g.wb_data;
   assign g0.req_valid = g.req_valid;
   assign g0.req_wid   = g.req_wid;
   assign g0.req_rs    = g.req_rs;
   assign g0.rsp_ready = g.rsp_ready;

   vx_gpr_file #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .DATAW(DW), .NUM_RPORTS(NP), .BYPASS(1))
      dut (.clk(clk), .reset(reset), .gpr(g));
   vx_gpr_file #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .DATAW(DW), .NUM_RPORTS(NP), .BYPASS(0))
      dut0 (.clk(clk), .reset(reset), .gpr(g0));

   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain array of lane values plus the expected response register
   logic [DW-1:0] mem [RAM][NT];
   int            left = RAM;
   logic          m_valid = 0;
   logic [1:0]    m_wid = 0;
   logic [RW-1:0] m_data1 = '0, m_data0 = '0;
   int            a;
   int            rs;
   logic [DW-1:0] v;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         left = RAM; m_valid = 0; m_wid = 0; m_data1 = '0; m_data0 = '0;
         foreach (mem[i, j]) mem[i][j] = '0;
      end else if (left > 0) begin
         left--;
      end else begin
         if (g.req_valid && (!m_valid || g.rsp_ready)) begin
            m_valid = 1;
            m_wid   = g.req_wid;
            for (int p = 0; p < NP; p++) begin
               rs = int'(g.req_rs[p*5 +: 5]);
               a  = int'(g.req_wid) * NR + rs;
               for (int t = 0; t < NT; t++) begin
                  v = (rs == 0) ? '0 : mem[a][t];
                  m_data0[(p*NT+t)*DW +: DW] = v;
                  m_data1[(p*NT+t)*DW +: DW] =
                     (rs != 0 && g.wb_valid && g.wb_wid == g.req_wid && int'(g.wb_rd) == rs && g.wb_tmask[t])
                     ? g.wb_data[t*DW +: DW] : v;
               end
            end
         end else if (g.rsp_ready) begin
            m_valid = 0;
         end
         if (g.wb_valid && g.wb_rd != 0)
            for (int t = 0; t < NT; t++)
               if (g.wb_tmask[t]) mem[int'(g.wb_wid)*NR + int'(g.wb_rd)][t] = g.wb_data[t*DW +: DW];
      end
   end

   always @(negedge clk) begin
      chk("init_done", g.init_done, left == 0);
      chk("wb_ready", g.wb_ready, left == 0);
      chk("req_ready", g.req_ready, left == 0 && (!m_valid || g.rsp_ready));
      chk("rsp_valid", g.rsp_valid, m_valid);
      chk("rsp_wid", g.rsp_wid, m_wid);
      chk("rsp_data", g.rsp_data, m_data1);
      chk("rsp_valid_nb", g0.rsp_valid, m_valid);
      chk("rsp_data_nb", g0.rsp_data, m_data0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      g.wb_valid = 0; g.wb_wid = 0; g.wb_rd = 0; g.wb_tmask = 0; g.wb_data = '0;
      g.req_valid = 0; g.req_wid = 0; g.req_rs = '0; g.rsp_ready = 1;
   endtask

   task automatic wb(input int wid, input int rd, input logic [NT-1:0] tm, input logic [NT*DW-1:0] d);
      g.wb_valid = 1; g.wb_wid = 2'(wid); g.wb_rd = 5'(rd); g.wb_tmask = tm; g.wb_data = d;
   endtask

   task automatic rq(input int wid, input int r0, input int r1, input int r2);
      g.req_valid = 1; g.req_wid = 2'(wid); g.req_rs = {5'(r2), 5'(r1), 5'(r0)};
   endtask

   task automatic wait_init();
      int n = 0;
      while (!g.init_done && n < 300) begin
         step();
         n++;
      end
      chk("init_cycles", n, 128);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [RW-1:0] e;
      int n;
      idle();
      repeat (3) step();
      reset = 0;
      wait_init();

      rq(3, 31, 31, 31); step(); g.req_valid = 0;
      chk("clear_valid", g.rsp_valid, 1);
      chk("clear_data", g.rsp_data, '0);

      wb(1, 5, 4'b0101, {4{32'hDEADBEEF}}); step(); g.wb_valid = 0;
      rq(1, 5, 5, 0); step(); g.req_valid = 0;
      e = '0;
      e[0 +: 32] = 32'hDEADBEEF; e[64 +: 32] = 32'hDEADBEEF;
      e[128 +: 32] = 32'hDEADBEEF; e[192 +: 32] = 32'hDEADBEEF;
      chk("wr_rd", g.rsp_data, e);

      wb(2, 0, 4'hF, {4{32'h00001234}}); step(); g.wb_valid = 0;
      rq(2, 0, 0, 0); step(); g.req_valid = 0;
      chk("r0_read", g.rsp_data, '0);

      wb(2, 7, 4'hF, {4{32'hA5A5A5A5}}); rq(2, 7, 7, 7); step(); idle();
      chk("bypass_on", g.rsp_data, {12{32'hA5A5A5A5}});
      chk("bypass_off", g0.rsp_data, '0);

      rq(2, 7, 0, 0); step();
      g.rsp_ready = 0; rq(3, 1, 2, 3); wb(2, 7, 4'hF, {4{32'h11111111}});
      repeat (3) begin
         step();
         chk("bp_ready", g.req_ready, 0);
         chk("bp_hold", g.rsp_data[31:0], 32'hA5A5A5A5);
      end
      g.wb_valid = 0; g.rsp_ready = 1; #1;
      chk("bp_release", g.req_ready, 1);
      step(); g.req_valid = 0;
      chk("bp_next_wid", g.rsp_wid, 3);

      n = 0;
      for (int i = 0; i < 16; i++) begin
         rq(i % 4, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
         step();
         if (g.rsp_valid) n++;
      end
      idle();
      chk("stream_count", n, 16);

      for (int i = 0; i < 3000; i++) begin
         g.wb_valid  = $urandom_range(0, 1) == 1;
         g.wb_wid    = 2'($urandom_range(0, 3));
         g.wb_rd     = 5'($urandom_range(0, 7));
         g.wb_tmask  = 4'($urandom);
         g.wb_data   = {$urandom, $urandom, $urandom, $urandom};
         g.req_valid = $urandom_range(0, 9) < 7;
         g.req_wid   = 2'($urandom_range(0, 3));
         g.req_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         g.rsp_ready = $urandom_range(0, 9) < 7;
         step();
      end

      idle();
      wb(1, 5, 4'hF, {4{32'hCAFEF00D}}); step(); idle();
      rq(1, 5, 5, 5); step();
      chk("pre_reset_valid", g.rsp_valid, 1);
      reset = 1; #1;
      chk("async_reset_valid", g.rsp_valid, 0);
      idle();
      step(); step();
      reset = 0;
      wait_init();
      rq(1, 5, 5, 5); step(); idle();
      chk("post_reset_valid", g.rsp_valid, 1);
      chk("post_reset_data", g.rsp_data, '0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
